dig_charge_pump: RTL and testbench
==================================

# dig_charge_pump

Synchronous, parametrised digital charge pump and loop-filter integrator for the frequency-synthesizer loop. Consumes UP/DOWN pulses from the phase-frequency detector, integrates them with independently programmable up and down step sizes, adds a programmable proportional kick, and drives a saturating control word to the oscillator tuning DAC. Replaces the fixed-current analog pump when the loop runs in digital mode. Also reports rail saturation and a consecutive-quiet-cycle lock indication.

## Interface
Parameters:
- WIDTH, 8, control word / integrator width
- STEP_W, 4, width of kup, kdn, kp step inputs (STEP_W < WIDTH)
- INIT, 2**(WIDTH-1), integrator and ctrl_out reset value
- LOCK_CNT, 16, consecutive quiet cycles required to assert locked (>= 1)

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  input  1  clock, all logic on rising edge
- wb_rst_i  input  1  synchronous active-high reset
- en  input  1  enable integration, proportional path and lock detection
- up  input  1  PFD up request (synchronous to wb_clk_i)
- down  input  1  PFD down request (synchronous to wb_clk_i)
- kup  input  STEP_W  integrator increment on up-only cycle
- kdn  input  STEP_W  integrator decrement on down-only cycle
- kp  input  STEP_W  proportional kick magnitude
- ctrl_out  output  WIDTH  control word to tuning DAC
- sat_hi  output  1  integrator at 2**WIDTH-1
- sat_lo  output  1  integrator at 0
- locked  output  1  LOCK_CNT consecutive quiet cycles seen

## Operation
- Stage 1: up, down registered into up_r, dn_r every cycle (regardless of en).
- Classify stage-1 state: INC = up_r & !dn_r; DEC = dn_r & !up_r; QUIET = otherwise (both or neither).
- Integrator acc (WIDTH bits), en=1: INC -> acc + kup; DEC -> acc - kdn; QUIET -> hold. Arithmetic in WIDTH+2-bit signed, clamp to [0, 2**WIDTH-1]. No wrap-around ever.
- Proportional path, en=1: ctrl_out = clamp(acc_next + kp) on INC, clamp(acc_next - kp) on DEC, acc_next on QUIET. Same clamp range.
- en=0: acc holds, ctrl_out = acc, lock counter cleared, locked = 0.
- sat_hi = (acc_next == 2**WIDTH-1); sat_lo = (acc_next == 0); both registered with acc.
- Lock detector: counter (clog2(LOCK_CNT+1) bits). QUIET and en -> increment, saturating at LOCK_CNT; INC or DEC -> clear to 0. locked = (counter_next == LOCK_CNT), registered.
- kup, kdn, kp sampled combinationally in stage 2; may change any cycle; no glitch protection required.
- kup=0 / kdn=0 legal: acc holds on that direction.

## Timing
- Reset (wb_rst_i=1 at edge): up_r=dn_r=0, acc=INIT, ctrl_out=INIT, sat_hi=sat_lo=0 (INIT=0 or max still reports 0 until first update), counter=0, locked=0. Reset overrides en and all inputs; reset mid-ramp discards integration immediately.
- Latency: up/down at edge k -> acc, ctrl_out, sat flags, locked updated at edge k+2.
- Single-cycle up pulse: ctrl_out shows acc+kup+kp for one cycle, then acc+kup.
- Back-to-back pulses integrate every cycle; throughput one update per clock.
- Simultaneous up and down: QUIET (hold, no kick, counts toward lock).
- Saturated: further steps toward the rail hold acc at rail; step away from rail leaves immediately and clears flag same edge.
- locked asserts exactly LOCK_CNT+1 edges after the last non-quiet stage-1 cycle with en=1 throughout; deasserts at the same edge a single-sided update lands.

## Test plan
- Reset: hold wb_rst_i 2 cycles with up=1 -> ctrl_out=128, acc=128, flags 0, locked 0 (WIDTH=8).
- Up pulse: en=1, kup=3, kp=2, one-cycle up -> ctrl_out 133 at k+2, 131 at k+3 and holding.
- Upper clamp: kup=15, up held 20 cycles from 128 -> ctrl_out reaches 255, sat_hi=1, never wraps; then one down with kdn=1, kp=0 -> 254, sat_hi=0.
- Lower clamp and asymmetry: kdn=15, down held -> 0 with sat_lo=1; kp=5 down kick at 0 -> ctrl_out stays 0.
- Lock: LOCK_CNT=16, en=1, up=down=1 for 20 cycles -> locked rises exactly 17 edges after last single-sided cycle; one up pulse -> locked drops at k+2.
- Enable gating: en=0, up pulses -> ctrl_out holds, locked=0; en=1 restores integration on next pulse; reset asserted mid-ramp -> ctrl_out=128 next edge.

Source files
------------

// File: rtl/dig_charge_pump.sv
// dig_charge_pump: PFD-driven saturating integrator with proportional kick and quiet-cycle lock detect
module dig_charge_pump #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int INIT     = 2**(WIDTH-1),
  parameter int LOCK_CNT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] kup,
  input  logic [STEP_W-1:0] kdn,
  input  logic [STEP_W-1:0] kp,
  output logic [WIDTH-1:0]  ctrl_out,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              locked
);
  localparam int CW = $clog2(LOCK_CNT+1);
  localparam int XW = WIDTH+2;
  localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];
  localparam logic [CW-1:0] LOCK_V = CW'(LOCK_CNT);
  logic up_r_q, dn_r_q, inc, dec;
  logic [WIDTH-1:0] acc_q, acc_d, ctrl_q, ctrl_d;
  logic [XW-1:0] acc_x, ctrl_x;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d, locked_q, locked_d;
  // Two extra bits: the top one flags underflow, the next one overflow past the rail
  function automatic logic [WIDTH-1:0] clamp(input logic [XW-1:0] s);
    return s[XW-1] ? '0 : s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction
  always_comb begin
    inc = up_r_q & ~dn_r_q;
    dec = dn_r_q & ~up_r_q;
    acc_x = inc ? {2'b00, acc_q} + XW'(kup) : dec ? {2'b00, acc_q} - XW'(kdn) : {2'b00, acc_q};
    acc_d = en ? clamp(acc_x) : acc_q;
    ctrl_x = inc ? {2'b00, acc_d} + XW'(kp) : dec ? {2'b00, acc_d} - XW'(kp) : {2'b00, acc_d};
    ctrl_d = en ? clamp(ctrl_x) : acc_d;
    cnt_d = (!en || inc || dec) ? '0 : (cnt_q == LOCK_V) ? cnt_q : cnt_q + CW'(1);
    locked_d = cnt_d == LOCK_V;
    sat_hi_d = acc_d == '1;
    sat_lo_d = acc_d == '0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      up_r_q   <= 1'b0;
      dn_r_q   <= 1'b0;
      acc_q    <= INIT_V;
      ctrl_q   <= INIT_V;
      cnt_q    <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      up_r_q   <= up;
      dn_r_q   <= down;
      acc_q    <= acc_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      locked_q <= locked_d;
    end
  end
  assign ctrl_out = ctrl_q;
  assign sat_hi   = sat_hi_q;
  assign sat_lo   = sat_lo_q;
  assign locked   = locked_q;
endmodule

// File: tb/tb_dig_charge_pump.sv
// tb_dig_charge_pump: scoreboarded random + directed bench against an arithmetic loop model
module tb_dig_charge_pump;
  localparam int W = 8, S = 4, L = 16, INIT = 128, MAX = 255;
  logic clk = 1'b0;
  logic rst, en, up, down;
  logic [S-1:0] kup, kdn, kp;
  logic [W-1:0] ctrl_out;
  logic sat_hi, sat_lo, locked;
  always #5 clk = ~clk;
  dig_charge_pump #(.WIDTH(W), .STEP_W(S), .INIT(INIT), .LOCK_CNT(L)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .up(up), .down(down),
    .kup(kup), .kdn(kdn), .kp(kp),
    .ctrl_out(ctrl_out), .sat_hi(sat_hi), .sat_lo(sat_lo), .locked(locked)
  );
  typedef struct {int ctrl; bit hi; bit lo; bit lk;} exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  bit done = 0;
  int m_acc, m_ctrl, m_cnt;
  bit m_pu, m_pd, m_hi, m_lo, m_lk;
  function automatic int clampi(int v);
    return v < 0 ? 0 : v > MAX ? MAX : v;
  endfunction
  task automatic check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Drive one cycle of stimulus, predict what the following edge must produce
  task automatic step(bit r, bit e, bit u, bit d, int ku, int kd, int k);
    int dir;
    exp_t x;
    rst = r; en = e; up = u; down = d;
    kup = S'(ku); kdn = S'(kd); kp = S'(k);
    if (r) begin
      m_pu = 0; m_pd = 0; m_acc = INIT; m_ctrl = INIT;
      m_cnt = 0; m_hi = 0; m_lo = 0; m_lk = 0;
    end else begin
      dir = (m_pu && !m_pd) ? 1 : (m_pd && !m_pu) ? -1 : 0;
      if (e) begin
        m_acc = clampi(m_acc + (dir > 0 ? ku : dir < 0 ? -kd : 0));
        m_ctrl = clampi(m_acc + dir * k);
        m_cnt = dir != 0 ? 0 : (m_cnt < L ? m_cnt + 1 : L);
      end else begin
        m_ctrl = m_acc;
        m_cnt = 0;
      end
      m_hi = m_acc == MAX; m_lo = m_acc == 0; m_lk = m_cnt == L;
      m_pu = u; m_pd = d;
    end
    x.ctrl = m_ctrl; x.hi = m_hi; x.lo = m_lo; x.lk = m_lk;
    q.push_back(x);
    @(negedge clk);
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (!done) begin
          compared++; mismatched++;
          $display("FAIL scoreboard: output edge with no expectation at %0t", $time);
        end
      end else begin
        x = q.pop_front();
        check("ctrl_out", int'(ctrl_out), x.ctrl);
        check("sat_hi", int'(sat_hi), int'(x.hi));
        check("sat_lo", int'(sat_lo), int'(x.lo));
        check("locked", int'(locked), int'(x.lk));
      end
    end
  end
  initial begin : driver
    int p;
    repeat (2) step(1, 0, 1, 0, 0, 0, 0);
    check("reset_ctrl", int'(ctrl_out), 128);
    check("reset_flags", int'({sat_hi, sat_lo, locked}), 0);
    step(0, 1, 1, 0, 3, 0, 2);
    step(0, 1, 0, 0, 3, 0, 2);
    check("kick_ctrl", int'(ctrl_out), 133);
    step(0, 1, 0, 0, 3, 0, 2);
    check("after_kick_ctrl", int'(ctrl_out), 131);
    step(0, 1, 0, 0, 3, 0, 2);
    check("hold_ctrl", int'(ctrl_out), 131);
    repeat (20) step(0, 1, 1, 0, 15, 0, 0);
    repeat (2) step(0, 1, 0, 0, 15, 0, 0);
    check("upper_clamp", int'(ctrl_out), 255);
    check("upper_sat_hi", int'(sat_hi), 1);
    step(0, 1, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    check("leave_upper", int'(ctrl_out), 254);
    check("leave_sat_hi", int'(sat_hi), 0);
    repeat (25) step(0, 1, 0, 1, 0, 15, 0);
    repeat (2) step(0, 1, 0, 0, 0, 15, 0);
    check("lower_clamp", int'(ctrl_out), 0);
    check("lower_sat_lo", int'(sat_lo), 1);
    step(0, 1, 0, 1, 0, 15, 5);
    step(0, 1, 0, 0, 0, 15, 5);
    check("lower_kick", int'(ctrl_out), 0);
    repeat (20) step(0, 1, 1, 1, 1, 1, 1);
    check("lock_rise", int'(locked), 1);
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    check("lock_drop", int'(locked), 0);
    repeat (4) begin
      step(0, 0, 1, 0, 4, 0, 3);
      step(0, 0, 0, 0, 4, 0, 3);
    end
    check("en_off_hold", int'(ctrl_out), 1);
    check("en_off_lock", int'(locked), 0);
    step(0, 1, 1, 0, 4, 0, 3);
    step(0, 1, 0, 0, 4, 0, 3);
    check("en_restore", int'(ctrl_out), 8);
    repeat (5) step(0, 1, 1, 0, 9, 0, 2);
    step(1, 1, 1, 0, 9, 0, 2);
    check("mid_ramp_reset", int'(ctrl_out), 128);
    for (int b = 0; b < 60; b++) begin
      p = $urandom_range(0, 2);
      for (int i = 0; i < 40; i++) begin
        bit u, d;
        u = $urandom_range(0, 1);
        d = (p == 0) ? u : $urandom_range(0, 1);
        step($urandom_range(0, 127) == 0, $urandom_range(0, 15) != 0, u, d,
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
    end
    done = 1;
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
